regfile_wb_sched: RTL

- Write-back scheduler for the 32x32 register file, which has one write port and two combinational read ports; $0 is hardwired to zero.
- Shares the single write port (wr/addr3/data3) among NREQ write-back requesters (ALU, load unit, exception unit) using round-robin valid/ready arbitration.
- Keeps a per-register busy scoreboard (reserve at issue, clear at commit) and flags read-after-write hazards for the two read addresses, so the control unit can stall.

---
 rtl/regfile_pkg.sv | 9 +
 rtl/rr_arbiter.sv | 36 +++
 rtl/regfile_wb_sched.sv | 77 +++++++
 3 files changed

// File: rtl/regfile_pkg.sv
// regfile_pkg: shared register-file widths and write-back requester indices
package regfile_pkg;
  localparam int REG_AW = 5;
  localparam int REG_DW = 32;
  localparam logic [REG_AW-1:0] REG_ZERO = 5'd0;
  localparam int WB_ALU = 0;
  localparam int WB_LOAD = 1;
  localparam int WB_EXC = 2;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: round-robin one-hot grant with rotating pointer and grant-index encoder
module rr_arbiter #(
  parameter int N = 3,
  localparam int IW = $clog2(N)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          en,
  input  logic [N-1:0]  valid,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx,
  output logic          any
);
  logic [IW-1:0] ptr;
  // search valids starting at ptr, wrapping, and grant the first hit
  always_comb begin : search
    int j;
    j = 0;
    grant = '0;
    idx = '0;
    any = 1'b0;
    for (int k = 0; k < N; k++) begin
      j = (int'(ptr) + k) % N;
      if (en && valid[j] && !any) begin
        grant[j] = 1'b1;
        idx = IW'(j);
        any = 1'b1;
      end
    end
  end
  // after a transfer the winner drops to lowest priority
  always_ff @(posedge clk) begin
    if (!reset) ptr <= '0;
    else if (any) ptr <= (idx == IW'(N-1)) ? '0 : idx + 1'b1;
  end
endmodule

// File: rtl/regfile_wb_sched.sv
// regfile_wb_sched: write-port arbitration, busy scoreboard and RAW hazard flags
module regfile_wb_sched
  import regfile_pkg::*;
#(
  parameter int NREQ = 3,
  parameter int AW = REG_AW,
  parameter int DW = REG_DW
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*DW-1:0] req_data,
  input  logic              rsv_valid,
  input  logic [AW-1:0]     rsv_addr,
  output logic              rsv_ready,
  input  logic              flush,
  input  logic [AW-1:0]     rd_addr1,
  input  logic [AW-1:0]     rd_addr2,
  output logic              hazard1,
  output logic              hazard2,
  output logic              wr,
  output logic [AW-1:0]     addr3,
  output logic [DW-1:0]     data3,
  output logic [31:0]       busy_vec
);
  localparam int IW = $clog2(NREQ);
  logic [IW-1:0] gidx;
  logic          xfer;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_data;
  logic [31:0]   busy_nxt;

  rr_arbiter #(.N(NREQ)) u_arb (
    .clk(clk),
    .reset(reset),
    .en(reset),
    .valid(req_valid),
    .grant(req_ready),
    .idx(gidx),
    .any(xfer)
  );

  // mux the winning requester's payload and derive reservation/hazard status
  always_comb begin
    sel_addr = req_addr[gidx*AW +: AW];
    sel_data = req_data[gidx*DW +: DW];
    rsv_ready = reset && (!busy_vec[rsv_addr] || rsv_addr == REG_ZERO);
    hazard1 = busy_vec[rd_addr1] && rd_addr1 != REG_ZERO;
    hazard2 = busy_vec[rd_addr2] && rd_addr2 != REG_ZERO;
  end

  // commit clears, reserve sets, flush wipes everything; $0 never busy
  always_comb begin
    busy_nxt = busy_vec;
    if (wr) busy_nxt[addr3] = 1'b0;
    if (rsv_valid && rsv_ready && rsv_addr != REG_ZERO) busy_nxt[rsv_addr] = 1'b1;
    if (flush) busy_nxt = '0;
    busy_nxt[0] = 1'b0;
  end

  // register the granted write one cycle after the grant; writes to $0 are swallowed
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr <= 1'b0;
      addr3 <= '0;
      data3 <= '0;
      busy_vec <= '0;
    end else begin
      wr <= xfer && sel_addr != REG_ZERO;
      if (xfer) addr3 <= sel_addr;
      if (xfer) data3 <= sel_data;
      busy_vec <= busy_nxt;
    end
  end
endmodule
